imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered, parametrised immediate-decode stage that sits between instruction fetch and the register-read/execute stage of the filter core. It extracts and sign-extends the immediate for every base RV32I/RV64I format, plus CSR zimm, shift amounts and the custom-0 WOS filter format. It precomputes the PC-relative target and flags unsupported opcodes. A valid/ready handshake with a 2-entry elastic buffer decouples fetch stalls from execute stalls.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CUSTOM_OP, 7'b0001011, opcode of the WOS filter instructions (custom-0).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous flush; discards all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; equals NOT skid_valid
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm / shamt), 7 C (custom)
- out_target  out  XLEN  out_pc + out_imm for B, J, AUIPC; 0 otherwise
- out_pc  out  XLEN  PC passed through
- out_illegal  out  1  opcode not recognised

## Operation
- Decode by opcode; sign-extend from instr[31] to XLEN:
  - OP-IMM, LOAD, JALR: I-format.
  - OP-IMM with funct3 001/101: fmt Z; imm is the zero-extended shamt, instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64.
  - OP-IMM-32 (0011011): valid only when XLEN=64. Follows OP-IMM rules, with shamt fixed at 5 bits.
  - STORE: S-format. BRANCH: B-format. JAL: J-format. LUI, AUIPC: U-format.
  - SYSTEM (1110011) with funct3[2]=1: fmt Z; imm is the zero-extended instr[19:15].
  - CUSTOM_OP: fmt C; imm is the zero-extended instr[31:20] (filter weight/window field).
  - Any other opcode: imm 0, fmt NONE, illegal 1.
  - OP (0110011), SYSTEM with funct3[2]=0, FENCE: imm 0, fmt NONE, illegal 0.
  - OP-IMM-32 when XLEN=32: treated as illegal.
- Target arithmetic: XLEN-bit add, wraps modulo 2^XLEN. JALR target is 0, because rs1 is not available here.
- Decode is combinational on the input side. Results are captured into the output register (main) and, under backpressure, the skid register.
- Buffer states: EMPTY (main invalid), ONE (main valid), FULL (main and skid valid).
  - EMPTY → ONE on accept.
  - ONE → FULL on accept while out_ready=0.
  - ONE → EMPTY on out_ready with no accept.
  - FULL → ONE on out_ready: skid moves to main; in_ready is 0 in FULL, so no accept occurs.
  - ONE with accept and out_ready: stays ONE; main is loaded with the new entry.
- Order is strictly preserved. There is no duplication and no loss.
- flush: both valids cleared at the edge; any entry accepted in the same cycle is discarded. Flush has priority over accept and over out_ready.

## Timing
- Accept occurs when in_valid & in_ready at a rising edge. Latency is 1 cycle: out_valid is high in the next cycle with decoded fields.
- Throughput is one instruction per cycle while out_ready=1.
- in_ready is driven purely from a register, with no combinational path from out_ready.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset values: out_valid 0, skid_valid 0, in_ready 1. out_imm, out_fmt, out_target, out_pc and out_illegal are all 0.
- While rst=1, in_valid is ignored.
- Reset mid-operation: all entries are dropped immediately and asynchronously. Accepts resume on the first edge after deassertion.
- Flush with in_valid=1: in_ready is 1 in the following cycle and out_valid is 0.

## Test plan
- XLEN=32: in_pc 0x100, in_instr 0xFE000EE3 (beq −4). Next cycle: out_imm 0xFFFFFFFC, fmt 3, out_target 0x000000FC, illegal 0.
- XLEN=32: LUI 0x123450B7 → imm 0x12345000, fmt 4, target 0. With in_pc 0xFFFFF000, AUIPC 0x00001097 → imm 0x00001000, target 0x00000000 (wrap).
- XLEN=64: 0xFFF00093 (addi −1) → imm 0xFFFFFFFFFFFFFFFF, fmt 1. 0x03F09093 (slli x1,x1,63) → imm 63, fmt 6.
- Unknown opcode 0x0000007F → imm 0, fmt 0, illegal 1. CUSTOM_OP word 0xABC0000B → imm 0xABC, fmt 7.
- Backpressure:
  - Hold out_ready=0 and offer instructions A, B, C back-to-back. A and B are accepted; in_ready drops after B, and C is held.
  - Raise out_ready. Output sequence is exactly A, B, C on consecutive cycles.
- Flush in FULL with in_valid=1 → next cycle out_valid 0, in_ready 1. No flushed entry ever appears on the output.
- Assert rst asynchronously mid-stream → out_valid falls without waiting for a clock edge, and all outputs read 0.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Immediate-decode stage: decodes RV32I/RV64I and custom-0 immediates, precomputes the
// PC-relative target, and buffers results in a two-entry elastic buffer.
module imm_decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [6:0]  CUSTOM_OP = 7'b0001011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpFence   = 7'b0001111;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
  localparam logic [2:0] FmtZ    = 3'd6;
  localparam logic [2:0] FmtC    = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} buf_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] shamt_x, shamt_w, zimm, cimm;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = sext32({{20{in_instr[31]}}, in_instr[31:20]});
  assign imm_s = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
  assign imm_b = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0});
  assign imm_u = sext32({in_instr[31:12], 12'h000});
  assign imm_j = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0});

  // Shift amounts are 6 bits wide only for full-width RV64 shifts.
  assign shamt_x = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign shamt_w = XLEN'(in_instr[24:20]);
  assign zimm    = XLEN'(in_instr[19:15]);
  assign cimm    = XLEN'(in_instr[31:20]);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic            dec_pcrel;

  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FmtNone;
    dec_illegal = 1'b0;
    dec_pcrel   = 1'b0;
    // Custom opcode is checked first so it wins over any standard encoding.
    if (opcode == CUSTOM_OP) begin
      dec_imm = cimm;
      dec_fmt = FmtC;
    end else begin
      case (opcode)
        OpOpImm: begin
          if (is_shift) begin
            dec_imm = shamt_x;
            dec_fmt = FmtZ;
          end else begin
            dec_imm = imm_i;
            dec_fmt = FmtI;
          end
        end
        OpOpImm32: begin
          if (XLEN == 64) begin
            if (is_shift) begin
              dec_imm = shamt_w;
              dec_fmt = FmtZ;
            end else begin
              dec_imm = imm_i;
              dec_fmt = FmtI;
            end
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OpLoad, OpJalr: begin
          dec_imm = imm_i;
          dec_fmt = FmtI;
        end
        OpStore: begin
          dec_imm = imm_s;
          dec_fmt = FmtS;
        end
        OpBranch: begin
          dec_imm   = imm_b;
          dec_fmt   = FmtB;
          dec_pcrel = 1'b1;
        end
        OpJal: begin
          dec_imm   = imm_j;
          dec_fmt   = FmtJ;
          dec_pcrel = 1'b1;
        end
        OpLui: begin
          dec_imm = imm_u;
          dec_fmt = FmtU;
        end
        OpAuipc: begin
          dec_imm   = imm_u;
          dec_fmt   = FmtU;
          dec_pcrel = 1'b1;
        end
        OpSystem: begin
          if (funct3[2]) begin
            dec_imm = zimm;
            dec_fmt = FmtZ;
          end
        end
        OpOp, OpFence: ;
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  entry_t dec_entry;

  always_comb begin
    dec_entry.imm     = dec_imm;
    dec_entry.fmt     = dec_fmt;
    dec_entry.target  = dec_pcrel ? (in_pc + dec_imm) : '0;
    dec_entry.pc      = in_pc;
    dec_entry.illegal = dec_illegal;
  end

  // ---------------------------------------------------------------------------
  // Elastic buffer control
  // ---------------------------------------------------------------------------
  buf_state_e state_q, state_d;
  logic       accept;
  logic       load_main, load_skid, move_skid;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !out_ready) begin
            state_d = StFull;
          end else if (!accept && out_ready) begin
            state_d = StEmpty;
          end
        end
        StFull:  if (out_ready) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // in_ready depends only on the state register, never on out_ready.
  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (!flush) begin
      case (state_q)
        StEmpty: load_main = accept;
        StOne: begin
          load_main = accept & out_ready;
          load_skid = accept & ~out_ready;
        end
        StFull:  move_skid = out_ready;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  entry_t main_q, skid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= dec_entry;
      end else if (move_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_entry;
      end
    end
  end

  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.target;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: one XLEN=32 and one XLEN=64 instance,
// hand-computed decode vectors, backpressure ordering, flush and async reset.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        flush32 = 1'b0, in_valid32 = 1'b0, out_ready32 = 1'b1;
  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] in_instr32 = '0, in_pc32 = '0;
  logic [31:0] out_imm32, out_target32, out_pc32;
  logic [2:0]  out_fmt32;

  // XLEN=64 instance
  logic        flush64 = 1'b0, in_valid64 = 1'b0, out_ready64 = 1'b1;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] in_instr64 = '0;
  logic [63:0] in_pc64 = '0;
  logic [63:0] out_imm64, out_target64, out_pc64;
  logic [2:0]  out_fmt64;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush32),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_instr(in_instr32), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_target(out_target32), .out_pc(out_pc32),
    .out_illegal(out_illegal32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_target(out_target64), .out_pc(out_pc64),
    .out_illegal(out_illegal64)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one instruction for a single cycle; returns on the negedge after the accept edge.
  task automatic send32(input logic [31:0] pc, input logic [31:0] instr);
    @(negedge clk);
    in_valid32 = 1'b1;
    in_pc32    = pc;
    in_instr32 = instr;
    @(negedge clk);
    in_valid32 = 1'b0;
  endtask

  task automatic send64(input logic [63:0] pc, input logic [31:0] instr);
    @(negedge clk);
    in_valid64 = 1'b1;
    in_pc64    = pc;
    in_instr64 = instr;
    @(negedge clk);
    in_valid64 = 1'b0;
  endtask

  task automatic expect32(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                          input logic [31:0] tgt, input logic ill);
    check({tag, "_valid"}, 64'(out_valid32), 64'd1);
    check({tag, "_imm"}, 64'(out_imm32), 64'(imm));
    check({tag, "_fmt"}, 64'(out_fmt32), 64'(fmt));
    check({tag, "_target"}, 64'(out_target32), 64'(tgt));
    check({tag, "_illegal"}, 64'(out_illegal32), 64'(ill));
  endtask

  task automatic expect64(input string tag, input logic [63:0] imm, input logic [2:0] fmt,
                          input logic [63:0] tgt, input logic ill);
    check({tag, "_valid"}, 64'(out_valid64), 64'd1);
    check({tag, "_imm"}, out_imm64, imm);
    check({tag, "_fmt"}, 64'(out_fmt64), 64'(fmt));
    check({tag, "_target"}, out_target64, tgt);
    check({tag, "_illegal"}, 64'(out_illegal64), 64'(ill));
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    check("rst_imm", 64'(out_imm32), 64'd0);
    check("rst_fmt", 64'(out_fmt32), 64'd0);
    check("rst_target", 64'(out_target32), 64'd0);
    check("rst_pc", 64'(out_pc32), 64'd0);
    check("rst_illegal", 64'(out_illegal32), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // XLEN=32 decode vectors
    send32(32'h100, 32'hFE000EE3);
    expect32("beq", 32'hFFFFFFFC, 3'd3, 32'h000000FC, 1'b0);
    check("beq_pc", 64'(out_pc32), 64'h100);
    send32(32'h0, 32'h123450B7);
    expect32("lui", 32'h12345000, 3'd4, 32'h0, 1'b0);
    send32(32'hFFFFF000, 32'h00001097);
    expect32("auipc_wrap", 32'h00001000, 3'd4, 32'h0, 1'b0);
    send32(32'h0, 32'h0000007F);
    expect32("unknown", 32'h0, 3'd0, 32'h0, 1'b1);
    send32(32'h0, 32'hABC0000B);
    expect32("custom", 32'h00000ABC, 3'd7, 32'h0, 1'b0);
    send32(32'h0, 32'hFE20AC23);
    expect32("sw", 32'hFFFFFFF8, 3'd2, 32'h0, 1'b0);
    send32(32'h1000, 32'h0080006F);
    expect32("jal", 32'h00000008, 3'd5, 32'h1008, 1'b0);
    send32(32'h0, 32'h300FD073);
    expect32("csrrwi", 32'h1F, 3'd6, 32'h0, 1'b0);
    send32(32'h0, 32'h41F0D093);
    expect32("srai", 32'h1F, 3'd6, 32'h0, 1'b0);
    send32(32'h0, 32'h00000033);
    expect32("op", 32'h0, 3'd0, 32'h0, 1'b0);
    send32(32'h0, 32'h00000073);
    expect32("ecall", 32'h0, 3'd0, 32'h0, 1'b0);
    send32(32'h0, 32'h0000001B);
    expect32("opimm32_rv32", 32'h0, 3'd0, 32'h0, 1'b1);
    send32(32'h400, 32'hFFC08067);
    expect32("jalr", 32'hFFFFFFFC, 3'd1, 32'h0, 1'b0);

    // XLEN=64 decode vectors
    send64(64'h0, 32'hFFF00093);
    expect64("addi64", 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h0, 1'b0);
    send64(64'h0, 32'h03F09093);
    expect64("slli63", 64'd63, 3'd6, 64'h0, 1'b0);
    send64(64'h0, 32'h03F0909B);
    expect64("slliw_5bit", 64'd31, 3'd6, 64'h0, 1'b0);
    send64(64'h0, 32'hFFF0009B);
    expect64("addiw", 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h0, 1'b0);
    send64(64'h100, 32'hFE000EE3);
    expect64("beq64", 64'hFFFFFFFFFFFFFFFC, 3'd3, 64'hFC, 1'b0);

    // Backpressure: A, B accepted, C held; drain in order
    @(negedge clk);
    out_ready32 = 1'b0;
    in_valid32  = 1'b1;
    in_instr32  = 32'h00100093;
    @(negedge clk);
    check("bp_a_valid", 64'(out_valid32), 64'd1);
    check("bp_a_imm", 64'(out_imm32), 64'd1);
    check("bp_ready_one", 64'(in_ready32), 64'd1);
    in_instr32 = 32'h00200093;
    @(negedge clk);
    check("bp_ready_full", 64'(in_ready32), 64'd0);
    check("bp_hold_a", 64'(out_imm32), 64'd1);
    in_instr32 = 32'h00300093;
    @(negedge clk);
    check("bp_ready_held", 64'(in_ready32), 64'd0);
    check("bp_stable_a", 64'(out_imm32), 64'd1);
    out_ready32 = 1'b1;
    @(negedge clk);
    check("bp_b_valid", 64'(out_valid32), 64'd1);
    check("bp_b_imm", 64'(out_imm32), 64'd2);
    check("bp_ready_after", 64'(in_ready32), 64'd1);
    @(negedge clk);
    check("bp_c_valid", 64'(out_valid32), 64'd1);
    check("bp_c_imm", 64'(out_imm32), 64'd3);
    in_valid32 = 1'b0;
    @(negedge clk);
    check("bp_drained", 64'(out_valid32), 64'd0);

    // Flush while FULL with in_valid high
    out_ready32 = 1'b0;
    in_valid32  = 1'b1;
    in_instr32  = 32'h00400093;
    @(negedge clk);
    in_instr32 = 32'h00500093;
    @(negedge clk);
    check("fl_full", 64'(in_ready32), 64'd0);
    flush32    = 1'b1;
    in_instr32 = 32'h00600093;
    @(negedge clk);
    check("fl_full_valid", 64'(out_valid32), 64'd0);
    check("fl_full_ready", 64'(in_ready32), 64'd1);
    // Flush in the same cycle as an accept discards it
    flush32    = 1'b0;
    in_instr32 = 32'h00700093;
    @(negedge clk);
    check("fl_one_valid", 64'(out_valid32), 64'd1);
    flush32    = 1'b1;
    in_instr32 = 32'h00800093;
    @(negedge clk);
    check("fl_accept_valid", 64'(out_valid32), 64'd0);
    check("fl_accept_ready", 64'(in_ready32), 64'd1);
    flush32     = 1'b0;
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    repeat (2) @(negedge clk);
    check("fl_no_ghost", 64'(out_valid32), 64'd0);
    send32(32'h0, 32'h00900093);
    expect32("fl_after", 32'd9, 3'd1, 32'h0, 1'b0);

    // Asynchronous reset mid-stream
    @(negedge clk);
    out_ready32 = 1'b0;
    in_valid32  = 1'b1;
    in_pc32     = 32'h200;
    in_instr32  = 32'hFE000EE3;
    @(negedge clk);
    check("ar_pre_valid", 64'(out_valid32), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid32), 64'd0);
    check("ar_ready", 64'(in_ready32), 64'd1);
    check("ar_imm", 64'(out_imm32), 64'd0);
    check("ar_fmt", 64'(out_fmt32), 64'd0);
    check("ar_target", 64'(out_target32), 64'd0);
    check("ar_pc", 64'(out_pc32), 64'd0);
    check("ar_illegal", 64'(out_illegal32), 64'd0);
    @(negedge clk);
    check("ar_held", 64'(out_valid32), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ar_resume_valid", 64'(out_valid32), 64'd1);
    check("ar_resume_pc", 64'(out_pc32), 64'h200);
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
